// File: rtl/data_unpacker_pkg.sv
// Shared definitions for the trace packer/unpacker pair: mode encoding and firmware byte width.
package data_unpacker_pkg;

  localparam int unsigned FW_W = 8;

  typedef enum logic [1:0] {
    MODE_N    = 2'd0,
    MODE_M    = 2'd1,
    MODE_1    = 2'd2,
    MODE_DROP = 2'd3
  } mode_e;

  function automatic mode_e fw_to_mode(input logic [FW_W-1:0] fw);
    case (fw)
      8'd0:    return MODE_N;
      8'd1:    return MODE_M;
      8'd2:    return MODE_1;
      default: return MODE_DROP;
    endcase
  endfunction

  function automatic int unsigned mode_len(input mode_e m, input int unsigned n,
                                           input int unsigned mm);
    case (m)
      MODE_N:  return n;
      MODE_M:  return mm;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/unpack_lane_select.sv
// Picks group g of slice p out of the held packed word and returns each element MSB-aligned.
module unpack_lane_select
  import data_unpacker_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned M          = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PRECISION  = 4,
  parameter int unsigned PW         = 2,
  parameter int unsigned GW         = 3
) (
  input  logic [N*DATA_WIDTH-1:0] hold_vec,
  input  logic [PW-1:0]           p,
  input  logic [GW-1:0]           g,
  input  mode_e                   mode,
  output logic [N*DATA_WIDTH-1:0] vector_out
);

  localparam int unsigned SW = DATA_WIDTH / PRECISION;

  always_comb begin
    int unsigned          len;
    int unsigned          lane;
    logic [N*DATA_WIDTH-1:0] shifted;
    vector_out = '0;
    lane       = 0;
    shifted    = '0;
    len        = mode_len(mode, N, M);
    for (int unsigned e = 0; e < N; e++) begin
      if (e < len) begin
        lane    = 32'(g) * len + e;
        shifted = hold_vec >> (lane * DATA_WIDTH + 32'(p) * SW);
        // Left shift keeps PRECISION=1 (SW == DATA_WIDTH) a plain pass-through.
        vector_out[e*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(shifted[SW-1:0]) << (DATA_WIDTH - SW);
      end
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Trace data unpacker: re-emits N-lane packed words as N-, M- or 1-element beats in arrival order.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int unsigned              N                  = 8,
  parameter int unsigned              M                  = 2,
  parameter int unsigned              DATA_WIDTH         = 32,
  parameter int unsigned              PRECISION          = 4,
  parameter int unsigned              MAX_CHAINS         = 4,
  parameter logic [7:0]               PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*FW_W-1:0] INITIAL_FIRMWARE = '0,
  localparam int unsigned             CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tracing,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [CW-1:0]           chainId_in,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [1:0]              len_out,
  output logic                    last_out
);

  localparam int unsigned PW = (PRECISION > 1) ? $clog2(PRECISION) : 1;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                  state;
  logic [N*DATA_WIDTH-1:0] hold_vec;
  mode_e                   hold_mode;
  logic [PW-1:0]           p;
  logic [GW-1:0]           g;
  logic [FW_W-1:0]         firmware [MAX_CHAINS];
  logic [7:0]              byte_counter;

  logic    busy, fire, accept, load;
  mode_e   in_mode;
  logic [GW-1:0] g_last;

  assign busy      = (state == ST_BUSY);
  assign valid_out = busy;
  assign len_out   = hold_mode;
  assign fire      = valid_out && ready_out;
  assign last_out  = busy && (p == PW'(PRECISION - 1)) && (g == g_last);
  assign ready_in  = reset_n && tracing && (!busy || (fire && last_out));
  assign accept    = valid_in && ready_in;
  assign in_mode   = fw_to_mode(firmware[chainId_in]);
  assign load      = accept && (in_mode != MODE_DROP);

  always_comb begin
    case (hold_mode)
      MODE_N:  g_last = '0;
      MODE_M:  g_last = GW'(N / M - 1);
      default: g_last = GW'(N - 1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hold_vec     <= '0;
      hold_mode    <= MODE_N;
      p            <= '0;
      g            <= '0;
      byte_counter <= '0;
      for (int unsigned i = 0; i < MAX_CHAINS; i++)
        firmware[i] <= INITIAL_FIRMWARE[i*FW_W +: FW_W];
    end else begin
      // A dropped word never touches the hold register; only the chain mode is needed later.
      if (load) begin
        state     <= ST_BUSY;
        hold_vec  <= vector_in;
        hold_mode <= in_mode;
        p         <= '0;
        g         <= '0;
      end else if (fire) begin
        if (last_out) begin
          state <= ST_IDLE;
        end else if (g == g_last) begin
          g <= '0;
          p <= p + 1'b1;
        end else begin
          g <= g + 1'b1;
        end
      end
      if (!tracing) begin
        if (configId == PERSONAL_CONFIG_ID) begin
          if (32'(byte_counter) < MAX_CHAINS)
            firmware[byte_counter[CW-1:0]] <= configData;
          if (byte_counter != 8'hFF)
            byte_counter <= byte_counter + 8'd1;
        end else begin
          byte_counter <= '0;
        end
      end
    end
  end

  unpack_lane_select #(
    .N(N),
    .M(M),
    .DATA_WIDTH(DATA_WIDTH),
    .PRECISION(PRECISION),
    .PW(PW),
    .GW(GW)
  ) u_lane_select (
    .hold_vec(hold_vec),
    .p(p),
    .g(g),
    .mode(hold_mode),
    .vector_out(vector_out)
  );

endmodule

// File: tb/tb_data_unpacker.sv
// Self-checking bench for data_unpacker against a queue-based beat model.
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NB = N * DW;

  logic          clk = 1'b0;
  logic          reset_n, tracing, valid_in, ready_out;
  logic [7:0]    configId, configData;
  logic [1:0]    chainId_in;
  logic [NB-1:0] vector_in, vector_out;
  logic          ready_in, valid_out, last_out;
  logic [1:0]    len_out;

  always #5 clk = ~clk;

  data_unpacker #(
    .N(8), .M(2), .DATA_WIDTH(32), .PRECISION(4), .MAX_CHAINS(4),
    .PERSONAL_CONFIG_ID(8'd0), .INITIAL_FIRMWARE(32'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tracing(tracing),
    .configId(configId), .configData(configData),
    .valid_in(valid_in), .ready_in(ready_in), .chainId_in(chainId_in),
    .vector_in(vector_in), .valid_out(valid_out), .ready_out(ready_out),
    .vector_out(vector_out), .len_out(len_out), .last_out(last_out)
  );

  typedef struct {
    logic [NB-1:0] vec;
    logic [1:0]    len;
    logic          last;
  } beat_t;

  beat_t      q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] fw_m [4];
  int         cfg_cnt;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats: slice by slice (oldest first), groups of L lanes, MSB-aligned.
  function automatic void push_word(input logic [NB-1:0] w, input int ch);
    logic [7:0] f = fw_m[ch];
    int L, G;
    if (f > 8'd2) return;
    L = (f == 8'd0) ? 8 : (f == 8'd1) ? 2 : 1;
    G = N / L;
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < G; g++) begin
        beat_t b;
        logic [NB-1:0] t;
        b.vec = '0;
        for (int e = 0; e < L; e++) begin
          t = w >> ((g * L + e) * 32 + p * 8);
          b.vec = b.vec | (NB'({t[7:0], 24'h0}) << (e * 32));
        end
        b.len  = f[1:0];
        b.last = (p == 3) && (g == G - 1);
        q.push_back(b);
      end
    end
  endfunction

  function automatic logic [NB-1:0] make_word(input int pat);
    logic [NB-1:0] w;
    for (int i = 0; i < N; i++) begin
      case (pat)
        1:       w[i*32 +: 32] = 32'hDDCCBBAA;
        2:       w[i*32 +: 32] = {4{8'(i + 1)}};
        default: w[i*32 +: 32] = $urandom;
      endcase
    end
    return w;
  endfunction

  task automatic cfg(input logic [7:0] id, input logic [7:0] d);
    @(negedge clk);
    tracing    = 1'b0;
    configId   = id;
    configData = d;
    #1;
    chk("cfg_ready_in", NB'(ready_in), NB'(1'b0));
    if (id == 8'd0) begin
      if (cfg_cnt < 4) fw_m[cfg_cnt] = d;
      if (cfg_cnt < 255) cfg_cnt++;
    end else begin
      cfg_cnt = 0;
    end
  endtask

  // bp: 0 = always ready, 1 = random stalls, 2 = three-cycle stall on beat 1 of each word.
  task automatic stream(input int nwords, input int chain, input int bp, input int pat);
    int            sent = 0, cyc = 0, cur_beat = 0, stall = 0, pc;
    logic          exp_rdy;
    logic [NB-1:0] pw;
    pw = make_word(pat);
    pc = (chain < 0) ? int'($urandom_range(0, 3)) : chain;
    while ((sent < nwords || q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      chk("valid_out", NB'(valid_out), NB'(q.size() != 0));
      if (q.size() != 0) begin
        chk("vector_out", vector_out, q[0].vec);
        chk("len_out", NB'(len_out), NB'(q[0].len));
        chk("last_out", NB'(last_out), NB'(q[0].last));
      end
      case (bp)
        0: ready_out = 1'b1;
        1: ready_out = ($urandom_range(0, 3) != 0);
        default: begin
          if (q.size() != 0 && cur_beat == 1 && stall < 3) begin
            ready_out = 1'b0;
            stall++;
          end else begin
            ready_out = 1'b1;
          end
        end
      endcase
      valid_in   = (sent < nwords);
      vector_in  = pw;
      chainId_in = 2'(pc);
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && ready_out);
      chk("ready_in", NB'(ready_in), NB'(exp_rdy));
      if (q.size() != 0 && ready_out) begin
        void'(q.pop_front());
        cur_beat++;
      end
      if (valid_in && exp_rdy) begin
        push_word(pw, pc);
        sent++;
        cur_beat = 0;
        stall    = 0;
        pw = make_word(pat);
        pc = (chain < 0) ? int'($urandom_range(0, 3)) : chain;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    chk("stream_done", NB'(sent == nwords && q.size() == 0), NB'(1'b1));
    @(negedge clk);
    chk("idle_valid_out", NB'(valid_out), NB'(1'b0));
  endtask

  initial begin
    reset_n    = 1'b0;
    tracing    = 1'b1;
    valid_in   = 1'b0;
    ready_out  = 1'b1;
    configId   = 8'hFF;
    configData = 8'h00;
    chainId_in = 2'd0;
    vector_in  = '0;
    for (int i = 0; i < 4; i++) fw_m[i] = 8'd0;
    cfg_cnt = 0;

    #12;
    chk("rst_valid_out", NB'(valid_out), NB'(1'b0));
    chk("rst_last_out", NB'(last_out), NB'(1'b0));
    chk("rst_len_out", NB'(len_out), NB'(2'd0));
    chk("rst_vector_out", vector_out, '0);
    chk("rst_ready_in", NB'(ready_in), NB'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    stream(1, 0, 0, 1);
    stream(3, 0, 1, 0);

    cfg(8'd5, 8'hAA);
    cfg(8'd0, 8'd2);
    cfg(8'd0, 8'd1);
    cfg(8'd0, 8'd0);
    cfg(8'd0, 8'd3);
    cfg(8'd0, 8'd7);
    @(negedge clk);
    tracing  = 1'b1;
    configId = 8'hFF;

    stream(1, 1, 0, 2);
    stream(1, 0, 0, 2);
    stream(2, 1, 2, 0);
    stream(2, 3, 0, 0);
    stream(12, -1, 1, 0);
    stream(4, -1, 0, 0);

    // Reset in the middle of a mode-N word on chain 2.
    @(negedge clk);
    valid_in   = 1'b1;
    chainId_in = 2'd2;
    vector_in  = make_word(0);
    push_word(vector_in, 2);
    #1;
    chk("mid_ready_in", NB'(ready_in), NB'(1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      chk("mid_valid_out", NB'(valid_out), NB'(1'b1));
      chk("mid_vector_out", vector_out, q[0].vec);
      if (k < 2) void'(q.pop_front());
    end
    reset_n = 1'b0;
    #1;
    chk("async_valid_out", NB'(valid_out), NB'(1'b0));
    chk("async_last_out", NB'(last_out), NB'(1'b0));
    chk("async_vector_out", vector_out, '0);
    chk("async_ready_in", NB'(ready_in), NB'(1'b0));
    q.delete();
    for (int i = 0; i < 4; i++) fw_m[i] = 8'd0;
    cfg_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    stream(1, 1, 0, 0);
    stream(1, 3, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
